exe_stage_unit: RTL and testbench

- Execute stage; consumes the ID/EX pipeline register outputs.
- Drives the Flush and branch-address signals back to IF/ID and the ID/EX register, and stall back to the front end.
- Single-cycle ALU ops plus a 32-iteration shift-add multiplier under an FSM.
- Registers its results into the EXE/MEM boundary.

---
 rtl/exe_stage_unit_if.sv | 41 ++++
 rtl/exe_stage_unit.sv | 185 ++++++++++++++++++
 tb/tb_exe_stage_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_unit_if.sv
// ID/EX-to-execute bundle: operand/control fields in, EXE/MEM results and
// front-end feedback (stall, Flush, Br_Addr) out.
interface exe_stage_unit_if #(
    parameter int WIDTH = 32
);
    logic             WB_En_in;
    logic             MEM_R_En_in;
    logic             MEM_W_En_in;
    logic [1:0]       BR_Type_in;
    logic [3:0]       EXE_Cmd_in;
    logic [4:0]       dest_in;
    logic [WIDTH-1:0] data1_in;
    logic [WIDTH-1:0] data2_in;
    logic [WIDTH-1:0] readdata2_in;
    logic [WIDTH-1:0] Immediate_in;
    logic [WIDTH-1:0] PC_in;

    logic             stall;
    logic             Flush;
    logic [WIDTH-1:0] Br_Addr;
    logic             WB_En;
    logic             MEM_R_En;
    logic             MEM_W_En;
    logic [4:0]       dest;
    logic [WIDTH-1:0] ALU_Result;
    logic [WIDTH-1:0] ST_Val;

    modport master (
        output WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type_in, EXE_Cmd_in,
               dest_in, data1_in, data2_in, readdata2_in, Immediate_in, PC_in,
        input  stall, Flush, Br_Addr, WB_En, MEM_R_En, MEM_W_En, dest,
               ALU_Result, ST_Val
    );

    modport slave (
        input  WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type_in, EXE_Cmd_in,
               dest_in, data1_in, data2_in, readdata2_in, Immediate_in, PC_in,
        output stall, Flush, Br_Addr, WB_En, MEM_R_En, MEM_W_En, dest,
               ALU_Result, ST_Val
    );
endinterface

// File: rtl/exe_stage_unit.sv
// Execute stage: single-cycle ALU, branch resolution and a 32-step shift-add
// multiplier that stalls the front end, registered into the EXE/MEM boundary.
module exe_stage_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    exe_stage_unit_if.slave    bus
);
    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRL = 4'b1001;
    localparam logic [3:0] CMD_SRA = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       m_dest_q, m_dest_d;
    logic             m_wb_q, m_wb_d;
    logic             m_mr_q, m_mr_d;
    logic             m_mw_q, m_mw_d;

    logic             wb_en_q, wb_en_d;
    logic             mem_r_q, mem_r_d;
    logic             mem_w_q, mem_w_d;
    logic [4:0]       dest_q, dest_d;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic [WIDTH-1:0] st_val_q, st_val_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] step_acc;
    logic [4:0]       sh;
    logic             is_mul;
    logic             taken;

    assign is_mul = (bus.EXE_Cmd_in == CMD_MUL);
    assign sh     = bus.data2_in[4:0];

    always_comb begin
        alu_res = '0;
        case (bus.EXE_Cmd_in)
            CMD_ADD: alu_res = bus.data1_in + bus.data2_in;
            CMD_SUB: alu_res = bus.data1_in - bus.data2_in;
            CMD_AND: alu_res = bus.data1_in & bus.data2_in;
            CMD_OR:  alu_res = bus.data1_in | bus.data2_in;
            CMD_NOR: alu_res = ~(bus.data1_in | bus.data2_in);
            CMD_XOR: alu_res = bus.data1_in ^ bus.data2_in;
            CMD_SLL: alu_res = bus.data1_in << sh;
            CMD_SRL: alu_res = bus.data1_in >> sh;
            CMD_SRA: alu_res = $unsigned($signed(bus.data1_in) >>> sh);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (bus.BR_Type_in)
            2'b01:   taken = (bus.data1_in == '0);
            2'b10:   taken = (bus.data1_in != bus.data2_in);
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Branch fields on a MUL are ignored, so it never flushes.
    assign bus.Flush   = rst && taken && !is_mul && (state_q == IDLE);
    assign bus.Br_Addr = bus.PC_in + (bus.Immediate_in << 2);
    assign bus.stall   = rst && (((state_q == IDLE) && is_mul) ||
                                 ((state_q == BUSY) && (cnt_q != 5'd31)));

    // Accumulator value after this cycle's iteration; on the last one it is
    // the finished product and goes straight into the output register.
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        m_dest_d     = m_dest_q;
        m_wb_d       = m_wb_q;
        m_mr_d       = m_mr_q;
        m_mw_d       = m_mw_q;
        wb_en_d      = 1'b0;
        mem_r_d      = 1'b0;
        mem_w_d      = 1'b0;
        dest_d       = '0;
        alu_result_d = '0;
        st_val_d     = '0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    mcand_d  = bus.data1_in;
                    mplier_d = bus.data2_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    m_dest_d = bus.dest_in;
                    m_wb_d   = bus.WB_En_in;
                    m_mr_d   = bus.MEM_R_En_in;
                    m_mw_d   = bus.MEM_W_En_in;
                    state_d  = BUSY;
                end else begin
                    wb_en_d      = bus.WB_En_in;
                    mem_r_d      = bus.MEM_R_En_in;
                    mem_w_d      = bus.MEM_W_En_in;
                    dest_d       = bus.dest_in;
                    alu_result_d = alu_res;
                    st_val_d     = bus.readdata2_in;
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d      = IDLE;
                    wb_en_d      = m_wb_q;
                    mem_r_d      = m_mr_q;
                    mem_w_d      = m_mw_q;
                    dest_d       = m_dest_q;
                    alu_result_d = step_acc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            m_dest_q     <= '0;
            m_wb_q       <= 1'b0;
            m_mr_q       <= 1'b0;
            m_mw_q       <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            dest_q       <= '0;
            alu_result_q <= '0;
            st_val_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            m_dest_q     <= m_dest_d;
            m_wb_q       <= m_wb_d;
            m_mr_q       <= m_mr_d;
            m_mw_q       <= m_mw_d;
            wb_en_q      <= wb_en_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
            dest_q       <= dest_d;
            alu_result_q <= alu_result_d;
            st_val_q     <= st_val_d;
        end
    end

    assign bus.WB_En      = wb_en_q;
    assign bus.MEM_R_En   = mem_r_q;
    assign bus.MEM_W_En   = mem_w_q;
    assign bus.dest       = dest_q;
    assign bus.ALU_Result = alu_result_q;
    assign bus.ST_Val     = st_val_q;
endmodule

// File: tb/tb_exe_stage_unit.sv
// Scoreboard bench for exe_stage_unit: the driver pushes per-cycle expectations
// from a behavioural model, an independent monitor pops and compares them.
module tb_exe_stage_unit;
    typedef struct packed {
        logic        wb, mr, mw;
        logic [1:0]  br;
        logic [3:0]  cmd;
        logic [4:0]  dest;
        logic [31:0] d1, d2, rd2, imm, pc;
    } instr_t;

    typedef struct packed {
        logic        stall, flush;
        logic [31:0] br_addr;
        logic        wb, mr, mw;
        logic [4:0]  dest;
        logic [31:0] alu, st;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_stage_unit_if #(.WIDTH(32)) bus();
    exe_stage_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pushed = 0;
    int   n_done = 0;

    // Behavioural model state: cycles left of an in-flight multiply.
    int          busy_left = 0;
    logic [31:0] pend_prod;
    logic [4:0]  pend_dest;
    logic        pend_wb, pend_mr, pend_mw;

    function automatic logic [31:0] ref_alu(input instr_t i);
        int unsigned s;
        s = i.d2 % 32;
        case (i.cmd)
            4'd0:  return i.d1 + i.d2;
            4'd2:  return i.d1 - i.d2;
            4'd4:  return i.d1 & i.d2;
            4'd5:  return i.d1 | i.d2;
            4'd6:  return ~(i.d1 | i.d2);
            4'd7:  return i.d1 ^ i.d2;
            4'd8:  return i.d1 << s;
            4'd9:  return i.d1 >> s;
            4'd10: return i.d1[31] ? ~((~i.d1) >> s) : (i.d1 >> s);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input instr_t i);
        case (i.br)
            2'd1:    return i.d1 == 32'd0;
            2'd2:    return i.d1 != i.d2;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of stimulus and push the model's expectation for it.
    task automatic drive(input instr_t i, input logic rst_v, output logic stall_o);
        exp_t    e;
        logic [63:0] p;
        @(negedge clk);
        rst = rst_v;
        bus.WB_En_in = i.wb;  bus.MEM_R_En_in = i.mr;  bus.MEM_W_En_in = i.mw;
        bus.BR_Type_in = i.br;  bus.EXE_Cmd_in = i.cmd;  bus.dest_in = i.dest;
        bus.data1_in = i.d1;  bus.data2_in = i.d2;  bus.readdata2_in = i.rd2;
        bus.Immediate_in = i.imm;  bus.PC_in = i.pc;
        e = '0;
        e.br_addr = i.pc + i.imm * 4;
        if (!rst_v) begin
            busy_left = 0;
        end else if (busy_left > 0) begin
            e.stall = (busy_left > 1);
            if (busy_left == 1) begin
                e.wb = pend_wb; e.mr = pend_mr; e.mw = pend_mw;
                e.dest = pend_dest; e.alu = pend_prod;
            end
            busy_left--;
        end else if (i.cmd == 4'd12) begin
            e.stall = 1'b1;
            p = 64'(i.d1) * 64'(i.d2);
            pend_prod = p[31:0];
            pend_dest = i.dest; pend_wb = i.wb; pend_mr = i.mr; pend_mw = i.mw;
            busy_left = 32;
        end else begin
            e.flush = ref_taken(i);
            e.wb = i.wb; e.mr = i.mr; e.mw = i.mw;
            e.dest = i.dest; e.alu = ref_alu(i); e.st = i.rd2;
        end
        exp_q.push_back(e);
        n_pushed++;
        stall_o = e.stall;
    endtask

    task automatic issue(input instr_t i);
        logic st;
        do drive(i, 1'b1, st); while (st);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.wb = 1'($urandom); i.mr = 1'($urandom); i.mw = 1'($urandom);
        i.br = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
        i.cmd = 4'($urandom);
        i.dest = 5'($urandom);
        i.d1 = pick_operand();
        i.d2 = ($urandom_range(0, 3) == 0) ? i.d1 : pick_operand();
        i.rd2 = $urandom; i.imm = $urandom; i.pc = $urandom;
        return i;
    endfunction

    function automatic instr_t mk(input logic [3:0] cmd, input logic [1:0] br,
                                  input logic [31:0] d1, input logic [31:0] d2);
        instr_t i;
        i = '0;
        i.cmd = cmd; i.br = br; i.d1 = d1; i.d2 = d2;
        i.dest = 5'd3; i.wb = 1'b1; i.rd2 = 32'hA5A5_0000 ^ d1; i.pc = 32'h40; i.imm = 32'd1;
        return i;
    endfunction

    // Monitor: combinational outputs mid-cycle, registered ones after the edge.
    initial begin
        exp_t e;
        logic st, fl;
        logic [31:0] ba;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                st = bus.stall; fl = bus.Flush; ba = bus.Br_Addr;
                @(posedge clk);
                #1;
                check("stall", 32'(st), 32'(e.stall));
                check("Flush", 32'(fl), 32'(e.flush));
                check("Br_Addr", ba, e.br_addr);
                check("WB_En", 32'(bus.WB_En), 32'(e.wb));
                check("MEM_R_En", 32'(bus.MEM_R_En), 32'(e.mr));
                check("MEM_W_En", 32'(bus.MEM_W_En), 32'(e.mw));
                check("dest", 32'(bus.dest), 32'(e.dest));
                check("ALU_Result", bus.ALU_Result, e.alu);
                check("ST_Val", bus.ST_Val, e.st);
                n_done++;
            end
        end
    end

    initial begin
        instr_t i;
        logic   st;
        int     waited;

        // Reset with random inputs on the bus.
        for (int k = 0; k < 2; k++) drive(rand_instr(), 1'b0, st);

        issue(mk(4'd0, 2'd0, 32'hFFFF_FFFF, 32'd1));
        issue(mk(4'd2, 2'd0, 32'd5, 32'd7));
        issue(mk(4'd10, 2'd0, 32'h8000_0000, 32'd4));
        issue(mk(4'd13, 2'd0, 32'h1234, 32'h5678));

        i = mk(4'd12, 2'd0, 32'h0001_0003, 32'd5);
        i.dest = 5'd9;
        issue(i);
        issue(mk(4'd5, 2'd0, 32'hF0, 32'h0F));
        issue(mk(4'd12, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));

        i = mk(4'd0, 2'd1, 32'd0, 32'd8);
        i.pc = 32'h100; i.imm = 32'd3; i.wb = 1'b0;
        issue(i);
        i = mk(4'd0, 2'd2, 32'h77, 32'h77);
        issue(i);
        i = mk(4'd0, 2'd3, 32'h1, 32'h2);
        i.pc = 32'h2000; i.imm = 32'hFFFF_FFFF;
        issue(i);

        // Abort a multiply with reset while its counter is at 10.
        i = mk(4'd12, 2'd0, 32'h0000_0007, 32'h0000_0009);
        for (int k = 0; k < 11; k++) drive(i, 1'b1, st);
        drive(i, 1'b0, st);
        issue(mk(4'd7, 2'd0, 32'hAAAA_0000, 32'h0000_5555));
        issue(mk(4'd8, 2'd0, 32'h1, 32'd31));

        for (int k = 0; k < 400; k++) issue(rand_instr());

        waited = 0;
        while (n_done != n_pushed && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        if (n_done != n_pushed) begin
            errors++;
            $display("FAIL drain actual=%0d expected=%0d", n_done, n_pushed);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
